// File: rtl/tdm_demux4.sv
// tdm_demux4: four-channel TDM demultiplexer.
// Frames are located by in_sof. Samples are assembled into four lane
// registers, and each completed frame goes to a single output holding slot
// with a valid/ready handshake. A framing violation raises sync_err for one
// cycle. A completed frame that finds the slot occupied is dropped and
// raises overflow for one cycle.
module tdm_demux4 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               in_sof,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic               sync_err,
  output logic               overflow,
  output logic [7:0]         frame_cnt
);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EXPECT  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [WIDTH-1:0]   lane_q [4];
  logic [WIDTH-1:0]   lane_d [4];
  logic [4*WIDTH-1:0] out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               sync_err_q, sync_err_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;

  logic               frame_done_s;
  logic               slot_free_s;
  logic               handshake_s;
  logic [4*WIDTH-1:0] frame_s;

  // Framing FSM: slot capture into lanes, frame completion and sync errors
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    sync_err_d   = 1'b0;
    frame_done_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      lane_d[i] = lane_q[i];
    end
    if (in_valid) begin
      case (state_q)
        ST_HUNT: begin
          if (in_sof) begin
            lane_d[0] = in_data;
            idx_d     = 2'd1;
            state_d   = ST_COLLECT;
          end else begin
            // Not yet aligned: drop the sample silently
            state_d = ST_HUNT;
          end
        end
        ST_COLLECT: begin
          if (in_sof) begin
            // Early start-of-frame: abandon the partial frame, restart at lane 0
            sync_err_d = 1'b1;
            lane_d[0]  = in_data;
            idx_d      = 2'd1;
            state_d    = ST_COLLECT;
          end else begin
            for (int i = 0; i < 4; i++) begin
              if (idx_q == 2'(i)) begin
                lane_d[i] = in_data;
              end else begin
                lane_d[i] = lane_q[i];
              end
            end
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              frame_done_s = 1'b1;
              state_d      = ST_EXPECT;
            end else begin
              state_d = ST_COLLECT;
            end
          end
        end
        ST_EXPECT: begin
          if (in_sof) begin
            lane_d[0] = in_data;
            idx_d     = 2'd1;
            state_d   = ST_COLLECT;
          end else begin
            // Frame boundary expected but missing: lose alignment
            sync_err_d = 1'b1;
            idx_d      = 2'd0;
            state_d    = ST_HUNT;
          end
        end
        default: begin
          idx_d   = 2'd0;
          state_d = ST_HUNT;
        end
      endcase
    end else begin
      // Gap between slots: everything holds
      state_d = state_q;
    end
  end

  // Completed frame: the lane-3 sample arrives directly from the input
  assign frame_s     = {in_data, lane_q[2], lane_q[1], lane_q[0]};
  assign handshake_s = out_valid_q & out_ready;
  assign slot_free_s = ~out_valid_q | out_ready;

  // Output slot: load, hold, release and overflow detection
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overflow_d  = 1'b0;
    if (frame_done_s) begin
      if (slot_free_s) begin
        out_data_d  = frame_s;
        out_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (handshake_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Delivered-frame counter, wraps modulo 256
  always_comb begin
    if (handshake_s) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HUNT;
      idx_q       <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        lane_q[i] <= '0;
      end
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      overflow_q  <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      for (int i = 0; i < 4; i++) begin
        lane_q[i] <= lane_d[i];
      end
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
      overflow_q  <= overflow_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign sync_err  = sync_err_q;
  assign overflow  = overflow_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 Parameter: WIDTH, default 8, bit width of one channel sample.
REQ-002 Single clock domain; reset asynchronous, active-low.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  in_data/in_sof carry one time-slot sample this cycle.
REQ-006 in_sof  input  1  marks the channel-0 slot of a frame; qualified by in_valid.
REQ-007 in_data  input  WIDTH  time-multiplexed sample.
REQ-008 out_valid  output  1  out_data holds a complete demultiplexed frame.
REQ-009 out_ready  input  1  consumer accepts out_data when out_valid is high.
REQ-010 out_data  output  4*WIDTH  packed frame {ch3,ch2,ch1,ch0}, ch0 in LSBs.
REQ-011 sync_err  output  1  one-cycle pulse on framing violation.
REQ-012 overflow  output  1  one-cycle pulse when a completed frame is dropped.
REQ-013 frame_cnt  output  8  count of frames delivered (handshakes), wraps 255->0.

Function
REQ-014 Block has no input backpressure: every in_valid cycle is consumed.
REQ-015 FSM states: HUNT, COLLECT, EXPECT; a 2-bit slot index idx selects the capture lane.
REQ-016 HUNT: in_valid&in_sof -> capture lane 0, idx=1, go COLLECT; in_valid&!in_sof -> discard, no flag.
REQ-017 COLLECT: in_valid&!in_sof -> capture lane idx, idx+1; on idx==3 frame completes, go EXPECT.
REQ-018 COLLECT: in_valid&in_sof -> sync_err pulse, partial frame abandoned, capture lane 0, idx=1, stay COLLECT.
REQ-019 EXPECT: in_valid&in_sof -> capture lane 0, idx=1, go COLLECT.
REQ-020 EXPECT: in_valid&!in_sof -> sync_err pulse, discard, go HUNT.
REQ-021 in_valid low in any state: no state, idx or lane change (gaps between slots allowed).
REQ-022 Frame completion loads out_data and sets out_valid on the next rising edge (latency 1 cycle after lane-3 sample).
REQ-023 Output slot is free if out_valid==0 or out_ready==1 in the completion cycle; simultaneous handshake and completion -> new frame loaded, out_valid stays 1.
REQ-024 Slot not free at completion -> frame dropped, overflow pulse next cycle, out_data unchanged.
REQ-025 While out_valid&!out_ready, out_data and out_valid hold stable.
REQ-026 out_valid&out_ready with no new completion -> out_valid cleared next cycle.
REQ-027 frame_cnt increments by 1 on each out_valid&out_ready cycle, modulo 256.
REQ-028 sync_err and overflow are registered, high exactly one cycle per event, never asserted together by the same input cycle except as specified.
REQ-029 Lanes not yet overwritten retain previous values; only completed frames ever reach out_data.

Reset
REQ-030 rst_n low: state=HUNT, idx=0, all lane registers 0, out_data=0, out_valid=0, sync_err=0, overflow=0, frame_cnt=0, immediately without clock.
REQ-031 Reset mid-frame discards the partial frame and any pending out_data; first frame after release requires in_sof.
REQ-032 Reset deassertion takes effect at the next rising clk edge.

Verification
REQ-033 Reset, then in_valid slots sof:0x11,0x22,0x33,0x44 with out_ready=1 -> out_valid one cycle after 0x44, out_data=0x44332211, frame_cnt=1.
REQ-034 Non-sof samples 0xAA,0xBB after reset, then a full frame -> AA/BB ignored, no sync_err, one frame delivered.
REQ-035 sof:0x01,0x02, then sof:0x10,0x20,0x30,0x40 -> one sync_err pulse, out_data=0x40302010, 0x01/0x02 never appear.
REQ-036 out_ready=0, two back-to-back frames -> first held stable, overflow pulse after second frame, frame_cnt unchanged until out_ready=1, then 1.
REQ-037 out_ready high in the exact cycle the next frame completes -> out_valid stays 1 continuously, both frames counted, no overflow.
REQ-038 rst_n pulsed low after slot 2 of a frame with a frame pending -> all outputs 0 asynchronously; subsequent non-sof slots discarded until next sof.
